// File: rtl/bcd_mod_timer.sv
// Two-digit BCD up/down timer with programmable terminal count.
// Wraps at 0/MAX_VAL with a one-cycle co pulse and range-checks loads.
module bcd_mod_timer #(
    parameter int MAX_VAL = 59,
    parameter int TENS_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [TENS_W-1:0] ld_tens,
    input  logic [3:0]        ld_ones,
    output logic [TENS_W-1:0] Q_L,
    output logic [3:0]        Q_R,
    output logic              co,
    output logic              tc,
    output logic              ld_err
);

    localparam int VW = TENS_W + 5;
    localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX_VAL / 10);
    localparam logic [3:0]        MAX_O = 4'(MAX_VAL % 10);
    localparam logic [VW-1:0]     MAX_V = VW'(MAX_VAL);

    logic [TENS_W-1:0] nl;
    logic [3:0]        nr;
    logic              nco;
    logic              nerr;
    logic              at_max;
    logic              at_zero;
    logic [VW-1:0]     ld_val;
    logic              ld_ok;

    assign at_max  = (Q_L == MAX_T) && (Q_R == MAX_O);
    assign at_zero = (Q_L == '0) && (Q_R == 4'd0);
    assign tc      = up_dn ? at_max : at_zero;

    // 10*t computed as 8*t + 2*t to stay shift/add only
    assign ld_val = (VW'(ld_tens) << 3) + (VW'(ld_tens) << 1) + VW'(ld_ones);
    assign ld_ok  = (ld_ones <= 4'd9) && (ld_val <= MAX_V);

    always_comb begin
        nl   = Q_L;
        nr   = Q_R;
        nco  = 1'b0;
        nerr = 1'b0;
        if (load) begin
            if (ld_ok) begin
                nl = ld_tens;
                nr = ld_ones;
            end else begin
                nl   = '0;
                nr   = 4'd0;
                nerr = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    nl  = '0;
                    nr  = 4'd0;
                    nco = 1'b1;
                end else if (Q_R == 4'd9) begin
                    nl = Q_L + TENS_W'(1);
                    nr = 4'd0;
                end else begin
                    nr = Q_R + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    nl  = MAX_T;
                    nr  = MAX_O;
                    nco = 1'b1;
                end else if (Q_R == 4'd0) begin
                    nl = Q_L - TENS_W'(1);
                    nr = 4'd9;
                end else begin
                    nr = Q_R - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q_L    <= '0;
            Q_R    <= 4'd0;
            co     <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            Q_L    <= nl;
            Q_R    <= nr;
            co     <= nco;
            ld_err <= nerr;
        end
    end

endmodule

// File: tb/tb_bcd_mod_timer.sv
// Scoreboard bench for bcd_mod_timer: default 0..59 instance
// and a 0..23 instance, directed stimulus with decimal expectations.
module tb_bcd_mod_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, up_a, ld_a;
    logic [2:0] lt_a;
    logic [3:0] lo_a;
    logic [2:0] ql_a;
    logic [3:0] qr_a;
    logic       co_a, tc_a, err_a;

    logic       rst_b, en_b, up_b, ld_b;
    logic [1:0] lt_b;
    logic [3:0] lo_b;
    logic [1:0] ql_b;
    logic [3:0] qr_b;
    logic       co_b, tc_b, err_b;

    bcd_mod_timer dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .up_dn(up_a), .load(ld_a),
        .ld_tens(lt_a), .ld_ones(lo_a), .Q_L(ql_a), .Q_R(qr_a),
        .co(co_a), .tc(tc_a), .ld_err(err_a)
    );

    bcd_mod_timer #(.MAX_VAL(23), .TENS_W(2)) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .up_dn(up_b), .load(ld_b),
        .ld_tens(lt_b), .ld_ones(lo_b), .Q_L(ql_b), .Q_R(qr_b),
        .co(co_b), .tc(tc_b), .ld_err(err_b)
    );

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       co;
        logic       err;
        logic       tc;
        int         id;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int total = 0;
    int bad = 0;
    int nid = 0;

    task automatic step(input bit b, input logic r, input logic e,
                        input logic u, input logic l, input int lt,
                        input int lo, input int v, input logic c,
                        input logic er);
        exp_t x;
        int mx;
        @(negedge clk);
        mx = b ? 23 : 59;
        if (!b) begin
            rst_a = r; en_a = e; up_a = u; ld_a = l;
            lt_a = 3'(lt); lo_a = 4'(lo);
        end else begin
            rst_b = r; en_b = e; up_b = u; ld_b = l;
            lt_b = 2'(lt); lo_b = 4'(lo);
        end
        x.t   = 4'(v / 10);
        x.o   = 4'(v % 10);
        x.co  = c;
        x.err = er;
        x.tc  = u ? (v == mx) : (v == 0);
        x.id  = nid;
        nid++;
        if (!b) q_a.push_back(x);
        else q_b.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        logic [3:0] at;
        logic [3:0] bt;
        #1;
        at = 4'(ql_a);
        bt = 4'(ql_b);
        if (q_a.size() > 0) begin
            x = q_a.pop_front();
            total++;
            if (at !== x.t || qr_a !== x.o || co_a !== x.co ||
                err_a !== x.err || tc_a !== x.tc) begin
                bad++;
                $display("FAIL a%0d: got q=%0d%0d co=%b err=%b tc=%b need q=%0d%0d co=%b err=%b tc=%b",
                         x.id, at, qr_a, co_a, err_a, tc_a,
                         x.t, x.o, x.co, x.err, x.tc);
            end
        end
        if (q_b.size() > 0) begin
            x = q_b.pop_front();
            total++;
            if (bt !== x.t || qr_b !== x.o || co_b !== x.co ||
                err_b !== x.err || tc_b !== x.tc) begin
                bad++;
                $display("FAIL b%0d: got q=%0d%0d co=%b err=%b tc=%b need q=%0d%0d co=%b err=%b tc=%b",
                         x.id, bt, qr_b, co_b, err_b, tc_b,
                         x.t, x.o, x.co, x.err, x.tc);
            end
        end
    end

    initial begin
        rst_a = 1; en_a = 0; up_a = 1; ld_a = 0; lt_a = 0; lo_a = 0;
        rst_b = 1; en_b = 0; up_b = 1; ld_b = 0; lt_b = 0; lo_b = 0;
        @(negedge clk);
        // reset wins over load and en
        step(0, 1, 1, 1, 1, 2, 5, 0, 0, 0);
        step(0, 1, 1, 1, 1, 2, 5, 0, 0, 0);
        // full up cycle 01..59 then wrap to 00
        for (int i = 1; i <= 60; i++)
            step(0, 0, 1, 1, 0, 0, 0, i % 60, i == 60, 0);
        // load 37 then count down through borrow and wrap
        step(0, 0, 1, 0, 1, 3, 7, 37, 0, 0);
        for (int i = 1; i <= 39; i++) begin
            int v;
            v = 37 - i;
            if (v < 0) v = v + 60;
            step(0, 0, 1, 0, 0, 0, 0, v, i == 38, 0);
        end
        // illegal loads and legal boundary loads
        step(0, 0, 0, 1, 1, 6, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 5, 15, 0, 0);
        step(0, 0, 1, 1, 1, 0, 12, 0, 0, 1);
        step(0, 0, 0, 1, 1, 7, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 5, 9, 59, 0, 0);
        // load at terminal with en suppresses wrap and co
        step(0, 0, 1, 1, 1, 2, 5, 25, 0, 0);
        for (int i = 26; i <= 42; i++)
            step(0, 0, 1, 1, 0, 0, 0, i, 0, 0);
        step(0, 1, 1, 1, 1, 3, 3, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        // direction change takes effect on the very next edge
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 59, 1, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // second instance: MAX_VAL=23
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 2, 0, 20, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 21, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 22, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 23, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0, 0, 0, 23, 1, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, i[0], 0, 0, 0, 23, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 22, 0, 0);
        step(1, 0, 0, 0, 1, 2, 4, 0, 0, 1);
        step(1, 0, 0, 0, 1, 3, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 1, 9, 19, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 20, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 20, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: left a=%0d b=%0d need 0",
                     q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_mod_timer.md
BCD_MOD_TIMER -- requirements
Module: bcd_mod_timer

Interface
REQ-001 Parameter MAX_VAL, default 59, meaning terminal count value, decimal, range 9..(10*2^TENS_W - 1).
REQ-002 Parameter TENS_W, default 3, meaning width of tens digit.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; one step per clk when high.
REQ-006 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 ld_tens  input  TENS_W  tens digit to load.
REQ-009 ld_ones  input  4  ones digit (BCD) to load.
REQ-010 Q_L  output  TENS_W  tens digit, registered.
REQ-011 Q_R  output  4  ones digit, BCD, registered.
REQ-012 co  output  1  wrap pulse, registered.
REQ-013 tc  output  1  at-terminal flag, combinational from Q_L/Q_R and up_dn.
REQ-014 ld_err  output  1  illegal-load pulse, registered.

Function
REQ-015 Counter value SHALL be V = 10*Q_L + Q_R; Q_R SHALL never exceed 9; V SHALL never exceed MAX_VAL.
REQ-016 Priority per edge SHALL be reset > load > en; inactive en with no load SHALL hold Q_L/Q_R.
REQ-017 Up step, Q_R<9 and V<MAX_VAL: Q_R+1, Q_L unchanged.
REQ-018 Up step, Q_R=9 and V<MAX_VAL: Q_R=0, Q_L+1 (decimal carry).
REQ-019 Up step, V=MAX_VAL: Q_L=0, Q_R=0, co=1 for that one cycle.
REQ-020 Down step, Q_R>0: Q_R-1.
REQ-021 Down step, Q_R=0 and Q_L>0: Q_R=9, Q_L-1 (decimal borrow).
REQ-022 Down step, V=0: load MAX_VAL digits (MAX_VAL/10, MAX_VAL%10), co=1 for that one cycle.
REQ-023 co SHALL be high exactly in the cycle following the wrapping edge, coincident with wrapped Q value; otherwise 0.
REQ-024 tc SHALL be 1 when (up_dn=1 and V=MAX_VAL) or (up_dn=0 and V=0), regardless of en.
REQ-025 Legal load (ld_ones<=9 and 10*ld_tens+ld_ones<=MAX_VAL): Q_L/Q_R take ld values next edge, ld_err=0.
REQ-026 Illegal load: Q_L=0, Q_R=0 next edge, ld_err=1 for one cycle.
REQ-027 load SHALL suppress counting and co in the same cycle, even if en=1 and V at terminal.
REQ-028 up_dn change SHALL take effect on the next enabled edge with no extra latency or skipped value.
REQ-029 Latency: one clk from en/load sample to updated Q; no pipeline beyond output registers.

Reset
REQ-030 On clk edge with reset=1: Q_L=0, Q_R=0, co=0, ld_err=0, overriding load and en.
REQ-031 Reset mid-count SHALL discard current value; counting resumes from 0 the first edge after reset deasserts with en=1.
REQ-032 Outputs before first reset edge are undefined; bench SHALL apply reset >=1 cycle before checking.

Verification
REQ-033 Default params, reset, en=1, up_dn=1 for 60 cycles -> Q sequence 00..59 then 00; co=1 only in the cycle Q=00 after 59; tc=1 only at 59.
REQ-034 Load 3/7, up_dn=0, en=1 for 39 cycles -> 37,36..00,59,58; co pulses once at 59; borrow 30->29 correct.
REQ-035 Load tens=6 ones=0 (V=60) -> Q=00, ld_err=1 one cycle; load ones=12 -> same response.
REQ-036 V=59, up_dn=1, load=1 with 2/5 and en=1 same edge -> Q=25, co=0.
REQ-037 Count to 42, assert reset with en=1 and load=1 -> Q=00, co=0, ld_err=0; deassert -> 01 next edge.
REQ-038 MAX_VAL=23, TENS_W=2, up count -> wraps 23->00 with co; down from 00 -> 23 with co; en=0 holds value for 5 cycles.
